// File: rtl/implication_chk_pkg.sv
// Shared types and helpers for the implication window checker: lane state,
// age counter width, popcount and saturating accumulate.
package implication_chk_pkg;

   localparam int unsigned AGE_W = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } lane_state_e;

   function automatic logic [5:0] popcnt32(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

   // Sum is formed one bit wider so the overflow past max is always visible.
   function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                           input logic [31:0] inc,
                                           input logic [31:0] max);
      logic [32:0] s;
      s = {1'b0, acc} + {1'b0, inc};
      if (s > {1'b0, max}) begin
         return max;
      end
      return s[31:0];
   endfunction

endpackage

// File: rtl/implication_chk_lane.sv
// One implication lane: IDLE/WAIT FSM with an age counter; emits a
// combinational pass/fail strobe for the edge on which the verdict is decided.
module implication_chk_lane
   import implication_chk_pkg::*;
#(
   parameter int unsigned MIN_DLY = 1,
   parameter int unsigned MAX_DLY = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic ant,
   input  logic cons,
   output logic pass,
   output logic fail
);

   localparam logic [AGE_W-1:0] MIN_A = AGE_W'(MIN_DLY);
   localparam logic [AGE_W-1:0] MAX_A = AGE_W'(MAX_DLY);
   localparam logic             MIN_Z = (MIN_DLY == 0);
   localparam logic             MAX_Z = (MAX_DLY == 0);

   lane_state_e      state_q, state_d;
   logic [AGE_W-1:0] age_q, age_d;

   always_comb begin
      state_d = state_q;
      age_d   = age_q;
      pass    = 1'b0;
      fail    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en && ant) begin
               if (MIN_Z && cons) begin
                  pass = 1'b1;
               end else if (MAX_Z) begin
                  fail = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  age_d   = AGE_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (!en) begin
               state_d = ST_IDLE;
               age_d   = '0;
            end else begin
               if (cons && (MIN_Z || age_q >= MIN_A)) begin
                  pass = 1'b1;
               end else if (age_q == MAX_A) begin
                  fail = 1'b1;
               end else begin
                  age_d = age_q + AGE_W'(1);
               end
               // A new antecedent on the verdict edge restarts the lane; when it
               // would itself pass immediately it is folded into this cycle's
               // single pass so the lane never emits two verdicts at once.
               if (pass || fail) begin
                  state_d = ST_IDLE;
                  age_d   = '0;
                  if (ant && !(MIN_Z && cons)) begin
                     state_d = ST_WAIT;
                     age_d   = AGE_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            age_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         age_q   <= '0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
      end
   end

endmodule

// File: rtl/implication_window_checker.sv
// Multi-channel "ant |-> ##[MIN_DLY:MAX_DLY] cons" monitor with registered
// verdict pulses, sticky fail flags and saturating global pass/fail counters.
module implication_window_checker
   import implication_chk_pkg::*;
#(
   parameter int unsigned CH      = 4,
   parameter int unsigned MIN_DLY = 1,
   parameter int unsigned MAX_DLY = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CH-1:0]    ant,
   input  logic [CH-1:0]    cons,
   input  logic             clr_sticky,
   output logic [CH-1:0]    pass_pulse,
   output logic [CH-1:0]    fail_pulse,
   output logic [CH-1:0]    fail_sticky,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   if (CH < 1 || CH > 32) begin : g_bad_ch
      $error("implication_window_checker: CH must be 1..32");
   end
   if (MIN_DLY > MAX_DLY || MAX_DLY > 255) begin : g_bad_dly
      $error("implication_window_checker: need MIN_DLY <= MAX_DLY <= 255");
   end
   if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
      $error("implication_window_checker: CNT_W must be 1..32");
   end

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CH-1:0]    pass_v, fail_v;
   logic [CH-1:0]    pass_pulse_q, fail_pulse_q, fail_sticky_q, fail_sticky_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

   for (genvar i = 0; i < CH; i++) begin : g_lane
      implication_chk_lane #(
         .MIN_DLY (MIN_DLY),
         .MAX_DLY (MAX_DLY)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .ant  (ant[i]),
         .cons (cons[i]),
         .pass (pass_v[i]),
         .fail (fail_v[i])
      );
   end

   // Sticky clear is gated by en so flags hold while checking is disabled;
   // a fail on the same edge as a clear wins.
   always_comb begin
      pass_cnt_d    = CNT_W'(sat_add(32'(pass_cnt_q), 32'(popcnt32(32'(pass_v))), CNT_MAX));
      fail_cnt_d    = CNT_W'(sat_add(32'(fail_cnt_q), 32'(popcnt32(32'(fail_v))), CNT_MAX));
      fail_sticky_d = (fail_sticky_q & ~{CH{clr_sticky & en}}) | fail_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pass_pulse_q  <= '0;
         fail_pulse_q  <= '0;
         fail_sticky_q <= '0;
         pass_cnt_q    <= '0;
         fail_cnt_q    <= '0;
      end else begin
         pass_pulse_q  <= pass_v;
         fail_pulse_q  <= fail_v;
         fail_sticky_q <= fail_sticky_d;
         pass_cnt_q    <= pass_cnt_d;
         fail_cnt_q    <= fail_cnt_d;
      end
   end

   assign pass_pulse  = pass_pulse_q;
   assign fail_pulse  = fail_pulse_q;
   assign fail_sticky = fail_sticky_q;
   assign pass_cnt    = pass_cnt_q;
   assign fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_implication_window_checker.sv
// Directed bench: five checker configurations, each driven through its own
// scenario with hand-computed expectations.
module tb_implication_window_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // u0: CH=1 MIN=1 MAX=2
   logic en0 = 0, ant0 = 0, cons0 = 0, clr0 = 0;
   logic pp0, fp0, fs0;
   logic [15:0] pc0, fc0;
   // u1: CH=1 MIN=2 MAX=3
   logic en1 = 0, ant1 = 0, cons1 = 0, clr1 = 0;
   logic pp1, fp1, fs1;
   logic [15:0] pc1, fc1;
   // u2: CH=1 MIN=0 MAX=0
   logic en2 = 0, ant2 = 0, cons2 = 0, clr2 = 0;
   logic pp2, fp2, fs2;
   logic [15:0] pc2, fc2;
   // u3: CH=4 MIN=1 MAX=2
   logic en3 = 0, clr3 = 0;
   logic [3:0] ant3 = '0, cons3 = '0;
   logic [3:0] pp3, fp3, fs3;
   logic [15:0] pc3, fc3;
   // u4: CH=1 MIN=1 MAX=2 CNT_W=4
   logic en4 = 0, ant4 = 0, cons4 = 0, clr4 = 0;
   logic pp4, fp4, fs4;
   logic [3:0] pc4, fc4;

   implication_window_checker #(.CH(1), .MIN_DLY(1), .MAX_DLY(2), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .en(en0), .ant(ant0), .cons(cons0), .clr_sticky(clr0),
      .pass_pulse(pp0), .fail_pulse(fp0), .fail_sticky(fs0), .pass_cnt(pc0), .fail_cnt(fc0));
   implication_window_checker #(.CH(1), .MIN_DLY(2), .MAX_DLY(3), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .en(en1), .ant(ant1), .cons(cons1), .clr_sticky(clr1),
      .pass_pulse(pp1), .fail_pulse(fp1), .fail_sticky(fs1), .pass_cnt(pc1), .fail_cnt(fc1));
   implication_window_checker #(.CH(1), .MIN_DLY(0), .MAX_DLY(0), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .en(en2), .ant(ant2), .cons(cons2), .clr_sticky(clr2),
      .pass_pulse(pp2), .fail_pulse(fp2), .fail_sticky(fs2), .pass_cnt(pc2), .fail_cnt(fc2));
   implication_window_checker #(.CH(4), .MIN_DLY(1), .MAX_DLY(2), .CNT_W(16)) u3 (
      .clk(clk), .rst(rst), .en(en3), .ant(ant3), .cons(cons3), .clr_sticky(clr3),
      .pass_pulse(pp3), .fail_pulse(fp3), .fail_sticky(fs3), .pass_cnt(pc3), .fail_cnt(fc3));
   implication_window_checker #(.CH(1), .MIN_DLY(1), .MAX_DLY(2), .CNT_W(4)) u4 (
      .clk(clk), .rst(rst), .en(en4), .ant(ant4), .cons(cons4), .clr_sticky(clr4),
      .pass_pulse(pp4), .fail_pulse(fp4), .fail_sticky(fs4), .pass_cnt(pc4), .fail_cnt(fc4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst_pp0", 32'(pp0), 0);
      chk("rst_fp0", 32'(fp0), 0);
      chk("rst_fs0", 32'(fs0), 0);
      chk("rst_pc0", 32'(pc0), 0);
      chk("rst_fc0", 32'(fc0), 0);
      chk("rst_fs3", 32'(fs3), 0);

      // ---- u0: MIN=1 MAX=2 ----
      en0 = 1;
      ant0 = 1; tick();
      ant0 = 0; chk("u0_e0_pp", 32'(pp0), 0);
      tick();   chk("u0_e1_pp", 32'(pp0), 0);
      chk("u0_e1_fp", 32'(fp0), 0);
      cons0 = 1; tick();
      chk("u0_e2_pass", 32'(pp0), 1);
      chk("u0_e2_pc", 32'(pc0), 1);
      cons0 = 0; tick();
      chk("u0_pass_1cyc", 32'(pp0), 0);
      ant0 = 1; tick();
      ant0 = 0; tick();
      chk("u0_fail_e1", 32'(fp0), 0);
      tick();
      chk("u0_fail_e2", 32'(fp0), 1);
      chk("u0_fail_pp", 32'(pp0), 0);
      chk("u0_fail_fs", 32'(fs0), 1);
      chk("u0_fail_fc", 32'(fc0), 1);
      tick();
      chk("u0_fail_1cyc", 32'(fp0), 0);
      chk("u0_fs_hold", 32'(fs0), 1);
      ant0 = 1; tick();
      ant0 = 0; cons0 = 1; tick();
      chk("u0_e1_pass", 32'(pp0), 1);
      chk("u0_e1_pc", 32'(pc0), 2);
      cons0 = 0;
      // back-to-back: fail edge restarts a new attempt
      ant0 = 1; tick();
      ant0 = 0; tick();
      ant0 = 1; tick();
      chk("u0_b2b_fail", 32'(fp0), 1);
      chk("u0_b2b_fc", 32'(fc0), 2);
      ant0 = 0; cons0 = 1; tick();
      chk("u0_b2b_pass", 32'(pp0), 1);
      chk("u0_b2b_pc", 32'(pc0), 3);
      cons0 = 0;
      // en dropped in WAIT
      ant0 = 1; tick();
      ant0 = 0; en0 = 0; tick();
      chk("u0_en_abort_fp", 32'(fp0), 0);
      en0 = 1; tick(); tick();
      chk("u0_en_pc", 32'(pc0), 3);
      chk("u0_en_fc", 32'(fc0), 2);
      cons0 = 1; tick();
      chk("u0_en_idle", 32'(pp0), 0);
      cons0 = 0;
      // en low in IDLE ignores ant
      en0 = 0; ant0 = 1; tick();
      en0 = 1; ant0 = 0; tick(); tick();
      chk("u0_en_ign_fc", 32'(fc0), 2);
      chk("u0_en_ign_fp", 32'(fp0), 0);
      // clr_sticky while en=0 holds the flag
      en0 = 0; clr0 = 1; tick();
      chk("u0_clr_en0", 32'(fs0), 1);
      en0 = 1; tick();
      clr0 = 0;
      chk("u0_clr", 32'(fs0), 0);
      // rst mid-attempt
      ant0 = 1; tick();
      ant0 = 0; rst = 1; tick();
      rst = 0;
      chk("u0_rst_pp", 32'(pp0), 0);
      chk("u0_rst_pc", 32'(pc0), 0);
      chk("u0_rst_fc", 32'(fc0), 0);
      cons0 = 1; tick();
      chk("u0_rst_idle", 32'(pp0), 0);
      cons0 = 0; tick(); tick();
      chk("u0_rst_nofail", 32'(fc0), 0);

      // ---- u1: MIN=2 MAX=3 ----
      en1 = 1;
      ant1 = 1; tick();
      cons1 = 1; tick();
      chk("u1_early_cons", 32'(pp1), 0);
      ant1 = 0; cons1 = 0; tick();
      chk("u1_e2", 32'(fp1), 0);
      tick();
      chk("u1_e3_fail", 32'(fp1), 1);
      chk("u1_e3_fc", 32'(fc1), 1);
      tick(); tick(); tick();
      chk("u1_no_extra_fc", 32'(fc1), 1);
      chk("u1_no_extra_pc", 32'(pc1), 0);
      ant1 = 1; tick();
      ant1 = 0; tick();
      cons1 = 1; tick();
      chk("u1_e2_pass", 32'(pp1), 1);
      chk("u1_e2_pc", 32'(pc1), 1);
      cons1 = 0;

      // ---- u2: MIN=0 MAX=0 ----
      en2 = 1;
      ant2 = 1; cons2 = 1; tick();
      chk("u2_same_pass", 32'(pp2), 1);
      chk("u2_same_pc", 32'(pc2), 1);
      cons2 = 0; tick();
      chk("u2_same_fail", 32'(fp2), 1);
      chk("u2_same_fs", 32'(fs2), 1);
      chk("u2_same_fc", 32'(fc2), 1);
      cons2 = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("u2_run_pp", 32'(pp2), 1);
      end
      chk("u2_run_pc", 32'(pc2), 6);
      ant2 = 0; cons2 = 0; tick();
      chk("u2_run_end", 32'(pp2), 0);

      // ---- u3: CH=4 ----
      en3 = 1;
      ant3 = 4'hF; tick();
      ant3 = 4'h0; tick();
      clr3 = 1; tick();
      chk("u3_all_fp", 32'(fp3), 32'hF);
      chk("u3_all_fc", 32'(fc3), 4);
      chk("u3_set_wins", 32'(fs3), 32'hF);
      tick();
      chk("u3_clr", 32'(fs3), 0);
      clr3 = 0;
      ant3 = 4'b0101; tick();
      ant3 = 4'b0000; cons3 = 4'b0001; tick();
      chk("u3_mix_pp", 32'(pp3), 32'h1);
      chk("u3_mix_pc", 32'(pc3), 1);
      cons3 = 4'b0000; tick();
      chk("u3_mix_fp", 32'(fp3), 32'h4);
      chk("u3_mix_fc", 32'(fc3), 5);
      chk("u3_mix_fs", 32'(fs3), 32'h4);

      // ---- u4: CNT_W=4 saturation ----
      en4 = 1;
      for (int i = 0; i < 20; i++) begin
         ant4 = 1; tick();
         ant4 = 0; cons4 = 1; tick();
         cons4 = 0;
         if (i == 14) chk("u4_pc_15", 32'(pc4), 15);
      end
      chk("u4_sat_pp", 32'(pp4), 1);
      chk("u4_sat_pc", 32'(pc4), 15);
      chk("u4_sat_fc", 32'(fc4), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/implication_window_checker.md
# implication_window_checker

Synthesizable multi-channel implication monitor: for each of CH channels it checks the property "antecedent ant[i] implies consequent cons[i] within MIN_DLY..MAX_DLY cycles". It is the hardware successor to our simulation-only A |-> B assertions and sits beside the logic under observation, in silicon or FPGA builds. It emits per-channel pass/fail pulses, sticky failure flags and saturating global pass/fail counters. An enable input gives the same semantics as a disable iff clause.

## Interface
- CH, 4: number of independent channels, 1..32
- MIN_DLY, 1: earliest accepted consequent, in cycles after the antecedent; 0 means the same cycle (overlapping |->)
- MAX_DLY, 2: last accepted cycle; MIN_DLY <= MAX_DLY <= 255, elaboration error otherwise
- CNT_W, 16: counter width
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  check enable; low aborts all pending attempts with no verdict
- ant  in  CH  antecedent per channel
- cons  in  CH  consequent per channel
- clr_sticky  in  1  clears fail_sticky
- pass_pulse  out  CH  one-cycle pass verdict
- fail_pulse  out  CH  one-cycle fail verdict
- fail_sticky  out  CH  set on a channel's first fail, held until clr_sticky or rst
- pass_cnt  out  CNT_W  total passes across all channels, saturating
- fail_cnt  out  CNT_W  total fails across all channels, saturating

## Operation
- Each lane has a 2-state FSM (IDLE, WAIT) and an 8-bit age counter. All inputs are sampled at posedge.
- IDLE with en=1 and ant=1:
  - If MIN_DLY=0 and cons=1: pass, stay in IDLE.
  - Else if MAX_DLY=0: fail, stay in IDLE.
  - Else go to WAIT with age=1.
- WAIT, checked in this order:
  - en=0: go to IDLE, no verdict.
  - cons=1 and age >= MIN_DLY: pass, go to IDLE.
  - age = MAX_DLY: fail, go to IDLE.
  - Otherwise age increments.
- A consequent before MIN_DLY is ignored.
- An antecedent arriving while the lane is in WAIT is ignored; there are no overlapping attempts per lane.
- Back-to-back attempts: on the edge where a lane leaves WAIT with a verdict, ant=1 with en=1 starts a new attempt from the IDLE rules in that same edge.
- Counters: each edge adds popcount(pass verdicts) to pass_cnt and popcount(fail verdicts) to fail_cnt. Each counter saturates at 2^CNT_W-1 and never wraps.
- fail_sticky[i] is set by a fail verdict.
  - clr_sticky clears it.
  - If clr_sticky and a fail verdict occur on the same edge, set wins.
- en=0 in IDLE: ant is ignored.
- Counters and sticky flags hold while en=0.

## Timing
- Reset values: all outputs 0, all lanes in IDLE, age=0.
- rst mid-attempt discards the attempt with no verdict.
- Verdict latency: a verdict decided from samples at edge t drives pass_pulse/fail_pulse high from edge t until edge t+1, for exactly one cycle. Outputs are registered.
- The counter and sticky updates from that verdict are visible after the same edge t.
- Example, MIN=1, MAX=2, antecedent sampled at edge 0:
  - cons at edge 1 or 2 gives pass after edge 1 or 2 respectively.
  - No cons at edges 1 and 2 gives fail after edge 2.
- MIN=0, MAX=0: ant and cons both at edge t give pass after t; ant alone gives fail after t.
- Per lane, at most one verdict per cycle; pass and fail pulses are mutually exclusive.

## Structure
- Package implication_chk_pkg:
  - lane state enum (IDLE, WAIT)
  - AGE_W=8 constant
  - saturating-add function for the counters
- Sub-module implication_chk_lane: one FSM with its age counter. Inputs en, ant, cons; outputs pass/fail verdict strobes.
- The top generates CH lanes plus the output registers, popcounts, saturating counters and sticky logic.

## Test plan
- MIN=1, MAX=2, CH=1: ant at edge 0, cons at edge 2 -> pass_pulse one cycle after edge 2, pass_cnt=1. Repeat with no cons -> fail_pulse after edge 2, fail_sticky=1, fail_cnt=1.
- MIN=2, MAX=3: cons at edge 1 only, then none -> early cons ignored, fail after edge 3. Second ant at edge 1 ignored (no extra verdict).
- MIN=0, MAX=0: ant and cons together -> pass after the same edge; ant alone -> fail after the same edge. Ant held high 5 cycles with cons high -> 5 passes, pass_cnt=5.
- CH=4: all lanes fail on the same edge -> fail_cnt += 4 in one cycle. Same edge as clr_sticky -> sticky=4'hF.
- en dropped in WAIT, and rst asserted in WAIT -> no pulses, counters unchanged, lane returns to IDLE. Back-to-back ant on a verdict edge starts a new attempt.
- CNT_W=4: drive 20 passes -> pass_cnt saturates at 15 and stays there.
